// File: rtl/alu_pkg.sv
// Shared types for param_alu: opcode encoding, control states and op classification.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_AND  = 3'b010,
        OP_XOR  = 3'b011,
        OP_MUL  = 3'b100,
        OP_SUB  = 3'b101,
        OP_OR   = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic is_single_cycle(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/alu_mult_pipe.sv
// Unsigned WIDTH x WIDTH multiplier delayed through MULT_STAGES registers; flush_n clears it.
module alu_mult_pipe #(
    parameter int WIDTH       = 8,
    parameter int MULT_STAGES = 3
) (
    input  logic                 clk,
    input  logic                 flush_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 out_valid
);

    logic [2*WIDTH-1:0]     prod_q [MULT_STAGES];
    logic [MULT_STAGES-1:0] valid_q;

    // Stage 0 captures the product at the accepting edge; later stages only delay it.
    always_ff @(posedge clk) begin
        if (!flush_n) begin
            valid_q <= '0;
            for (int i = 0; i < MULT_STAGES; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            prod_q[0]  <= {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
            for (int i = 1; i < MULT_STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                prod_q[i]  <= prod_q[i-1];
            end
        end
    end

    assign product   = prod_q[MULT_STAGES-1];
    assign out_valid = valid_q[MULT_STAGES-1];

endmodule

// File: rtl/param_alu.sv
// Parametrised ALU with single-cycle logic/arith ops and a pipelined multiply.
// Optional zero/carry flag outputs are enabled by defining PARAM_ALU_FLAGS_EN.
module param_alu
    import alu_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MULT_STAGES = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 ready,
    output logic                 done,
    output logic                 err,
`ifdef PARAM_ALU_FLAGS_EN
    output logic                 zero,
    output logic                 carry,
`endif
    output logic [2*WIDTH-1:0]   result
);

    state_e               state, state_next;
    op_e                  op_dec;
    logic                 accept;
    logic                 mult_valid;
    logic [2*WIDTH-1:0]   mult_product;
    logic [2*WIDTH-1:0]   alu_value;

    assign op_dec = op_e'(op);
    assign ready  = (state == IDLE);
    assign accept = start && ready;

    alu_mult_pipe #(
        .WIDTH       (WIDTH),
        .MULT_STAGES (MULT_STAGES)
    ) u_mult (
        .clk       (clk),
        .flush_n   (reset_n),
        .in_valid  (accept && (op_dec == OP_MUL)),
        .a         (A),
        .b         (B),
        .product   (mult_product),
        .out_valid (mult_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && (op_dec == OP_MUL)) state_next = BUSY;
            BUSY:    if (mult_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ADD/SUB keep carry/borrow in bit WIDTH; logic ops occupy only the low WIDTH bits.
    always_comb begin
        alu_value = '0;
        case (op_dec)
            OP_ADD:  alu_value[WIDTH:0]   = {1'b0, A} + {1'b0, B};
            OP_SUB:  alu_value[WIDTH:0]   = {1'b0, A} - {1'b0, B};
            OP_AND:  alu_value[WIDTH-1:0] = A & B;
            OP_OR:   alu_value[WIDTH-1:0] = A | B;
            OP_XOR:  alu_value[WIDTH-1:0] = A ^ B;
            default: alu_value = '0;
        endcase
    end

    // Ready gating means a multiply completion never coincides with an accepted start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
`ifdef PARAM_ALU_FLAGS_EN
            zero   <= 1'b0;
            carry  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (mult_valid) begin
                done   <= 1'b1;
                result <= mult_product;
`ifdef PARAM_ALU_FLAGS_EN
                zero   <= (mult_product == '0);
                carry  <= 1'b0;
`endif
            end else if (accept && is_single_cycle(op_dec)) begin
                done   <= 1'b1;
                result <= alu_value;
`ifdef PARAM_ALU_FLAGS_EN
                zero   <= (alu_value == '0);
                carry  <= ((op_dec == OP_ADD) || (op_dec == OP_SUB)) ? alu_value[WIDTH] : 1'b0;
`endif
            end else if (accept && (op_dec == OP_RSVD)) begin
                done   <= 1'b1;
                err    <= 1'b1;
`ifdef PARAM_ALU_FLAGS_EN
                zero   <= 1'b0;
                carry  <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_param_alu.sv
// Directed, table-driven bench for param_alu (WIDTH=8, MULT_STAGES=3).
module tb_param_alu;
    import alu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        ready;
    logic        done;
    logic        err;
    logic [15:0] result;
`ifdef PARAM_ALU_FLAGS_EN
    logic        zero;
    logic        carry;
`endif

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        zero;
        logic        carry;
    } vec_t;

    vec_t vecs[9];

    param_alu #(
        .WIDTH       (8),
        .MULT_STAGES (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .A       (a_in),
        .B       (b_in),
        .ready   (ready),
        .done    (done),
        .err     (err),
`ifdef PARAM_ALU_FLAGS_EN
        .zero    (zero),
        .carry   (carry),
`endif
        .result  (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: actual %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic [2:0] o,
                                  input logic [7:0] a, input logic [7:0] b);
        start = s;
        op    = o;
        a_in  = a;
        b_in  = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string name, input logic z, input logic c);
`ifdef PARAM_ALU_FLAGS_EN
        check_output({name, " zero"}, {31'd0, zero}, {31'd0, z});
        check_output({name, " carry"}, {31'd0, carry}, {31'd0, c});
`else
        if (z === 1'bx && c === 1'bx) $display("[TB] %s flags unused", name);
`endif
    endtask

    initial begin
        vecs[0] = '{OP_ADD, 8'd200, 8'd100, 16'h012C, 1'b0, 1'b1};
        vecs[1] = '{OP_SUB, 8'd5,   8'd7,   16'h01FE, 1'b0, 1'b1};
        vecs[2] = '{OP_ADD, 8'hFF,  8'hFF,  16'h01FE, 1'b0, 1'b1};
        vecs[3] = '{OP_SUB, 8'd7,   8'd5,   16'h0002, 1'b0, 1'b0};
        vecs[4] = '{OP_AND, 8'hF0,  8'h3C,  16'h0030, 1'b0, 1'b0};
        vecs[5] = '{OP_OR,  8'hF0,  8'h3C,  16'h00FC, 1'b0, 1'b0};
        vecs[6] = '{OP_XOR, 8'hF0,  8'h3C,  16'h00CC, 1'b0, 1'b0};
        vecs[7] = '{OP_XOR, 8'hAA,  8'hAA,  16'h0000, 1'b1, 1'b0};
        vecs[8] = '{OP_SUB, 8'd0,   8'd0,   16'h0000, 1'b1, 1'b0};

        reset_n = 1'b0;
        apply_stimulus(1'b0, OP_NOP, 8'd0, 8'd0);
        step();
        step();
        check_output("reset ready",  {31'd0, ready}, 32'd1);
        check_output("reset done",   {31'd0, done},  32'd0);
        check_output("reset err",    {31'd0, err},   32'd0);
        check_output("reset result", {16'd0, result}, 32'd0);
        check_flags("reset", 1'b0, 1'b0);
        reset_n = 1'b1;

        // Back-to-back single-cycle ops, one per clock.
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            step();
            check_output($sformatf("vec%0d done", i),   {31'd0, done},  32'd1);
            check_output($sformatf("vec%0d err", i),    {31'd0, err},   32'd0);
            check_output($sformatf("vec%0d ready", i),  {31'd0, ready}, 32'd1);
            check_output($sformatf("vec%0d result", i), {16'd0, result}, {16'd0, vecs[i].res});
            check_flags($sformatf("vec%0d", i), vecs[i].zero, vecs[i].carry);
        end

        apply_stimulus(1'b0, OP_ADD, 8'd1, 8'd2);
        step();
        check_output("idle done", {31'd0, done}, 32'd0);

        // Reserved opcode flags an error and keeps the previous result.
        apply_stimulus(1'b1, OP_RSVD, 8'd9, 8'd9);
        step();
        check_output("rsvd done",   {31'd0, done}, 32'd1);
        check_output("rsvd err",    {31'd0, err},  32'd1);
        check_output("rsvd result", {16'd0, result}, 32'h0000);
        check_flags("rsvd", 1'b0, 1'b0);

        apply_stimulus(1'b1, OP_ADD, 8'd3, 8'd4);
        step();
        check_output("add7 result", {16'd0, result}, 32'h0007);

        apply_stimulus(1'b1, OP_NOP, 8'd50, 8'd60);
        step();
        check_output("nop done",   {31'd0, done}, 32'd0);
        check_output("nop err",    {31'd0, err},  32'd0);
        check_output("nop result", {16'd0, result}, 32'h0007);

        // Multiply: busy for three cycles, ignoring starts and operand changes.
        apply_stimulus(1'b1, OP_MUL, 8'd255, 8'd255);
        step();
        check_output("mul busy1 ready", {31'd0, ready}, 32'd0);
        check_output("mul busy1 done",  {31'd0, done},  32'd0);
        apply_stimulus(1'b1, OP_ADD, 8'd1, 8'd1);
        step();
        check_output("mul busy2 ready", {31'd0, ready}, 32'd0);
        check_output("mul busy2 done",  {31'd0, done},  32'd0);
        apply_stimulus(1'b1, OP_MUL, 8'd2, 8'd3);
        step();
        check_output("mul busy3 ready", {31'd0, ready}, 32'd0);
        check_output("mul busy3 done",  {31'd0, done},  32'd0);
        apply_stimulus(1'b0, OP_NOP, 8'h00, 8'h00);
        step();
        check_output("mul done",   {31'd0, done},  32'd1);
        check_output("mul ready",  {31'd0, ready}, 32'd1);
        check_output("mul err",    {31'd0, err},   32'd0);
        check_output("mul result", {16'd0, result}, 32'hFE01);
        check_flags("mul", 1'b0, 1'b0);
        step();
        check_output("mul after done",   {31'd0, done}, 32'd0);
        check_output("mul held result",  {16'd0, result}, 32'hFE01);

        apply_stimulus(1'b1, OP_MUL, 8'd12, 8'd13);
        step();
        apply_stimulus(1'b0, OP_NOP, 8'd0, 8'd0);
        step();
        step();
        check_output("mul2 not early", {31'd0, done}, 32'd0);
        step();
        check_output("mul2 done",   {31'd0, done}, 32'd1);
        check_output("mul2 result", {16'd0, result}, 32'h009C);

        // Reset during a multiply aborts it without a done.
        apply_stimulus(1'b1, OP_MUL, 8'd3, 8'd4);
        step();
        apply_stimulus(1'b0, OP_NOP, 8'd0, 8'd0);
        step();
        reset_n = 1'b0;
        step();
        check_output("abort ready",  {31'd0, ready}, 32'd1);
        check_output("abort done",   {31'd0, done},  32'd0);
        check_output("abort result", {16'd0, result}, 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_output($sformatf("abort quiet%0d done", i), {31'd0, done}, 32'd0);
            check_output($sformatf("abort quiet%0d ready", i), {31'd0, ready}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
